// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a word-organised SRAM. It inserts programmable
// wait states, merges byte/halfword writes, and gives a two-cycle ERROR for illegal transfers.
module ahb_sram_subordinate #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WA_W  = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t                  state_reg;
  state_t                  accept_state;
  logic [3:0]              wait_cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [1:0]              lane_reg;
  logic [1:0]              size_reg;
  logic                    write_reg;
  logic                    hreadyout_reg;
  logic                    hresp_reg;
  logic [DATA_WIDTH-1:0]   hrdata_reg;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    accept;
  logic                    illegal;
  logic                    misaligned;
  logic                    out_of_range;
  logic [WA_W-1:0]         word_addr;
  logic [IDX_W-1:0]        haddr_idx;
  logic [IDX_W-1:0]        rd_idx;
  logic [3:0]              wr_be;
  logic                    write_commit;
  logic                    fwd_hit;
  logic [DATA_WIDTH-1:0]   mem_word;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  assign accept       = HSEL & HREADY & HTRANS[1];
  assign word_addr    = HADDR[ADDR_WIDTH-1:2];
  assign haddr_idx    = HADDR[IDX_W+1:2];
  assign out_of_range = (word_addr >= WA_W'(MEM_DEPTH));
  assign misaligned   = ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign illegal      = out_of_range || (HSIZE > 3'd2) || misaligned;
  assign accept_state = illegal ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA);

  always_comb begin
    wr_be = 4'b1111;
    case (size_reg)
      2'd0:    wr_be = 4'b0001 << lane_reg;
      2'd1:    wr_be = lane_reg[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
  end

  assign write_commit = (state_reg == ST_DATA) && write_reg;

  // A zero-wait read reads at its own address-phase edge, which can be the same
  // edge a previous write commits on; forward the written lanes in that case.
  assign rd_idx   = (state_reg == ST_WAIT) ? idx_reg : haddr_idx;
  assign fwd_hit  = write_commit && (idx_reg == rd_idx);
  assign mem_word = mem[rd_idx];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_word[8*gi +: 8] = (fwd_hit && wr_be[gi]) ? HWDATA[8*gi +: 8]
                                                         : mem_word[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge HCLK) begin
    if (write_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx_reg][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= 4'd0;
      idx_reg       <= '0;
      lane_reg      <= 2'd0;
      size_reg      <= 2'd0;
      write_reg     <= 1'b0;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= 1'b0;
      hrdata_reg    <= '0;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg - 4'd1;
          if (wait_cnt_reg == 4'd1) begin
            state_reg     <= ST_DATA;
            hreadyout_reg <= 1'b1;
            if (!write_reg) hrdata_reg <= rd_word;
          end
        end
        ST_ERR1: begin
          state_reg     <= ST_ERR2;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= 1'b1;
        end
        default: begin
          // ST_IDLE, ST_DATA and ST_ERR2 can all take a new address phase
          if (accept) begin
            state_reg     <= accept_state;
            idx_reg       <= haddr_idx;
            lane_reg      <= HADDR[1:0];
            size_reg      <= HSIZE[1:0];
            write_reg     <= HWRITE;
            wait_cnt_reg  <= 4'(WAIT_STATES);
            hreadyout_reg <= (accept_state == ST_DATA);
            hresp_reg     <= illegal;
            if ((accept_state == ST_DATA) && !HWRITE) hrdata_reg <= rd_word;
          end else begin
            state_reg     <= ST_IDLE;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_reg;
  assign HRESP     = hresp_reg;
  assign HRDATA    = hrdata_reg;

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Scoreboard bench: two subordinates (0 and 3 wait states) share one bus; a monitor
// pops expected transfers as data phases complete and compares against a byte-lane SRAM model.
module tb_ahb_sram_subordinate;

  localparam int MEM_DEPTH = 1024;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        hsel_b  = 1'b0;
  logic [31:0] HADDR   = 32'h0;
  logic [1:0]  HTRANS  = 2'b00;
  logic        HWRITE  = 1'b0;
  logic [2:0]  HSIZE   = 3'd0;
  logic [2:0]  HBURST  = 3'd0;
  logic [3:0]  HPROT   = 4'h3;
  logic [31:0] HWDATA  = 32'h0;
  logic        sel     = 1'b0;
  logic        stall   = 1'b0;

  logic        ro0, ro3, resp0, resp3;
  logic [31:0] rd0, rd3;
  logic        HREADY, bus_resp;
  logic [31:0] bus_rdata;

  always #5 HCLK = ~HCLK;

  assign HREADY    = stall ? 1'b0 : (sel ? ro3 : ro0);
  assign bus_resp  = sel ? resp3 : resp0;
  assign bus_rdata = sel ? rd3 : rd0;

  ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_b & ~sel), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0)
  );

  ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(3)) u_dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_b & sel), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(ro3), .HRESP(resp3), .HRDATA(rd3)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    int          waits;
  } txn_t;

  txn_t        q[$];
  logic [31:0] model0 [int];
  logic [31:0] model3 [int];
  int          checks = 0;
  int          errors = 0;
  logic        data_active = 1'b0;
  int          wait_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_illegal(input logic [31:0] a, input logic [2:0] sz);
    return ((a >> 2) >= 32'(MEM_DEPTH)) || (sz > 3'd2) ||
           ((sz == 3'd1) && a[0]) || ((sz == 3'd2) && (a[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] model_rd(input logic s, input int idx);
    if (s) return model3.exists(idx) ? model3[idx] : 32'h0;
    return model0.exists(idx) ? model0[idx] : 32'h0;
  endfunction

  function automatic void model_wr(input logic s, input logic [31:0] a, input logic [2:0] sz,
                                   input logic [31:0] wd);
    logic [31:0] w;
    logic [3:0]  be;
    w = model_rd(s, int'(a >> 2));
    case (sz)
      3'd0:    be = 4'b0001 << a[1:0];
      3'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    if (s) model3[int'(a >> 2)] = w;
    else   model0[int'(a >> 2)] = w;
  endfunction

  // Monitor: judges the data phase in flight, then notes whether the address
  // phase on the bus will be taken at the coming edge.
  initial begin
    txn_t t;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        data_active = 1'b0;
        wait_cnt    = 0;
      end else begin
        if (data_active) begin
          if (!HREADY) begin
            wait_cnt++;
            if (q.size() > 0) check("lowresp", 32'(bus_resp), 32'(q[0].err));
          end else if (q.size() == 0) begin
            check("sb_underflow", 32'(q.size()), 32'd1);
          end else begin
            t = q.pop_front();
            check("resp", 32'(bus_resp), 32'(t.err));
            check("waits", 32'(wait_cnt), 32'(t.waits));
            if (!t.err && !t.write) check("rdata", bus_rdata, model_rd(sel, int'(t.addr >> 2)));
            if (!t.err && t.write) model_wr(sel, t.addr, t.size, t.wdata);
            $display("txn dut_ws%0d %s addr=%h size=%0d resp=%0d rdata=%h waits=%0d",
                     sel ? 3 : 0, t.write ? "WR" : "RD", t.addr, t.size, bus_resp, bus_rdata, wait_cnt);
            wait_cnt = 0;
          end
        end
        if (HREADY) data_active = hsel_b && HTRANS[1];
      end
    end
  end

  task automatic wait_accept();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge HCLK);
      if (HREADY) seen = 1'b1;
    end
    check("accept_seen", 32'(seen), 32'd1);
    @(posedge HCLK);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [1:0] tr);
    txn_t t;
    t.write = w;
    t.addr  = a;
    t.size  = sz;
    t.wdata = wd;
    t.err   = is_illegal(a, sz);
    t.waits = t.err ? 1 : (sel ? 3 : 0);
    q.push_back(t);
    hsel_b = 1'b1;
    HADDR  = a;
    HTRANS = tr;
    HWRITE = w;
    HSIZE  = sz;
    wait_accept();
    HWDATA = wd;
  endtask

  task automatic idle();
    hsel_b = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    wait_accept();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;

    repeat (3) @(posedge HCLK);
    #1;
    check("rst_ready0", 32'(ro0), 32'd1);
    check("rst_resp0", 32'(resp0), 32'd0);
    check("rst_rdata0", rd0, 32'h0);
    check("rst_ready3", 32'(ro3), 32'd1);
    check("rst_resp3", 32'(resp3), 32'd0);
    check("rst_rdata3", rd3, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    check("post_rst_ready0", 32'(ro0), 32'd1);
    check("post_rst_resp0", 32'(resp0), 32'd0);

    // zero-wait subordinate
    sel = 1'b0;
    issue(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 2'b10);
    issue(1'b0, 32'h10, 3'd2, 32'h0, 2'b10);
    idle();
    check("rd_deadbeef", bus_rdata, 32'hDEADBEEF);
    issue(1'b1, 32'h13, 3'd0, 32'hA5000000, 2'b10);
    issue(1'b0, 32'h10, 3'd2, 32'h0, 2'b10);
    idle();
    check("rd_byte_merge", bus_rdata, 32'hA5ADBEEF);
    issue(1'b1, 32'h10, 3'd1, 32'h00001234, 2'b10);
    issue(1'b0, 32'h10, 3'd2, 32'h0, 2'b10);
    idle();
    check("rd_half_merge", bus_rdata, 32'hA5AD1234);

    issue(1'b1, 32'h20, 3'd2, 32'h11223344, 2'b10);
    issue(1'b0, 32'h20, 3'd2, 32'h0, 2'b10);
    idle();
    check("raw_fwd", bus_rdata, 32'h11223344);

    issue(1'b0, 32'(4 * MEM_DEPTH), 3'd2, 32'h0, 2'b10);
    issue(1'b1, 32'h11, 3'd1, 32'hFFFFFFFF, 2'b10);
    issue(1'b1, 32'h12, 3'd3, 32'hFFFFFFFF, 2'b10);
    issue(1'b0, 32'h10, 3'd2, 32'h0, 2'b10);
    idle();
    check("err_no_write", bus_rdata, 32'hA5AD1234);

    // another subordinate stalls the bus: nothing may be sampled
    stall  = 1'b1;
    hsel_b = 1'b1;
    HADDR  = 32'h10;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HSIZE  = 3'd2;
    HWDATA = 32'h0;
    repeat (2) @(posedge HCLK);
    #1;
    check("stall_ready", 32'(ro0), 32'd1);
    check("stall_resp", 32'(resp0), 32'd0);
    stall = 1'b0;
    issue(1'b0, 32'h10, 3'd2, 32'h0, 2'b10);
    idle();
    check("stall_no_write", bus_rdata, 32'hA5AD1234);

    for (int i = 0; i < 4; i++) issue(1'b1, 32'h40 + 32'(4 * i), 3'd2, $urandom, 2'b10);
    for (int i = 0; i < 12; i++) begin
      sz = 3'($urandom_range(0, 2));
      a  = 32'h40 + 32'($urandom_range(0, 15));
      a  = a & ~((32'd1 << sz) - 32'd1);
      issue(1'b1, a, sz, $urandom, 2'b10);
      issue(1'b0, a & ~32'd3, 3'd2, 32'h0, 2'b10);
    end
    idle();

    // three-wait subordinate
    sel = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) issue(1'b1, 32'h10 + 32'(4 * i), 3'd2, 32'hC0DE0000 + 32'(i), (i == 0) ? 2'b10 : 2'b11);
    for (int i = 0; i < 4; i++) issue(1'b0, 32'h10 + 32'(4 * i), 3'd2, 32'h0, (i == 0) ? 2'b10 : 2'b11);
    idle();
    check("ws_last_read", bus_rdata, 32'hC0DE0003);
    issue(1'b0, 32'h11, 3'd1, 32'h0, 2'b10);
    issue(1'b1, 32'h30, 3'd2, 32'hCAFEF00D, 2'b10);
    idle();

    // reset while a write to 0x30 is still in its wait states
    issue(1'b1, 32'h30, 3'd2, 32'h0BADF00D, 2'b10);
    hsel_b = 1'b0;
    HTRANS = 2'b00;
    check("ws_low_before_rst", 32'(ro3), 32'd0);
    #2;
    HRESETn = 1'b0;
    q.delete();
    #1;
    check("rst_mid_ready", 32'(ro3), 32'd1);
    check("rst_mid_resp", 32'(resp3), 32'd0);
    check("rst_mid_rdata", rd3, 32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    issue(1'b0, 32'h30, 3'd2, 32'h0, 2'b10);
    idle();
    check("rst_write_dropped", bus_rdata, 32'hCAFEF00D);

    idle();
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
